// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone classic arbiter.
// Round-robin grant held for a whole cyc tenure, with a bus watchdog
// that turns a hung slave into an err response.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   wb_m0_* / wb_m1_*   master ports (cyc,stb,we,sel,addr,data_wr in;
//                       data_rd,ack,err out)
//   wb_s_*              shared slave port (request out, response in)
//   o_grant             registered one-hot grant {m1,m0}, 00 when idle
//   o_timeout           one-cycle pulse when the watchdog aborts
// Option: define WBARB_FIXED_PRIORITY_EN to let m0 win every tie.
module wb_arbiter2 #(
   parameter int TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        wb_m0_cyc,
   input  logic        wb_m0_stb,
   input  logic        wb_m0_we,
   input  logic [3:0]  wb_m0_sel,
   input  logic [31:0] wb_m0_addr,
   input  logic [31:0] wb_m0_data_wr,
   output logic [31:0] wb_m0_data_rd,
   output logic        wb_m0_ack,
   output logic        wb_m0_err,
   input  logic        wb_m1_cyc,
   input  logic        wb_m1_stb,
   input  logic        wb_m1_we,
   input  logic [3:0]  wb_m1_sel,
   input  logic [31:0] wb_m1_addr,
   input  logic [31:0] wb_m1_data_wr,
   output logic [31:0] wb_m1_data_rd,
   output logic        wb_m1_ack,
   output logic        wb_m1_err,
   output logic        wb_s_cyc,
   output logic        wb_s_stb,
   output logic        wb_s_we,
   output logic [3:0]  wb_s_sel,
   output logic [31:0] wb_s_addr,
   output logic [31:0] wb_s_data_wr,
   input  logic [31:0] wb_s_data_rd,
   input  logic        wb_s_ack,
   input  logic        wb_s_err,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t           state;
   logic             last_grant;
   logic [CNT_W-1:0] wdog;

   logic sel0, sel1, resp, g_cyc, g_stb;
   logic req0, req1, pick1, wdog_fire;

   assign sel0 = (state == GNT0);
   assign sel1 = (state == GNT1);
   assign resp = wb_s_ack | wb_s_err;

   assign g_cyc = (sel0 & wb_m0_cyc) | (sel1 & wb_m1_cyc);
   assign g_stb = (sel0 & wb_m0_stb) | (sel1 & wb_m1_stb);

   // The master just aborted by the watchdog is still holding cyc while
   // it sees the err; keep it out of the arbitration in that cycle.
   assign req0 = wb_m0_cyc & ~(o_timeout & ~last_grant);
   assign req1 = wb_m1_cyc & ~(o_timeout & last_grant);

`ifdef WBARB_FIXED_PRIORITY_EN
   assign pick1 = req1 & ~req0;
`else
   assign pick1 = req1 & (~req0 | ~last_grant);
`endif

   assign wdog_fire = g_stb & ~resp
                    & (wdog == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wdog       <= '0;
         o_grant    <= 2'b00;
         o_timeout  <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               wdog <= '0;
               if (req0 | req1) begin
                  state   <= pick1 ? GNT1 : GNT0;
                  o_grant <= pick1 ? 2'b10 : 2'b01;
               end
            end
            GNT0, GNT1: begin
               if (!g_cyc || wdog_fire) begin
                  state      <= IDLE;
                  o_grant    <= 2'b00;
                  last_grant <= sel1;
                  wdog       <= '0;
                  o_timeout  <= g_cyc;
               end else if (resp || !g_stb) begin
                  wdog <= '0;
               end else begin
                  wdog <= wdog + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               o_grant <= 2'b00;
            end
         endcase
      end
   end

   always_comb begin
      wb_s_cyc     = g_cyc;
      wb_s_stb     = g_stb;
      wb_s_we      = 1'b0;
      wb_s_sel     = 4'h0;
      wb_s_addr    = 32'h0;
      wb_s_data_wr = 32'h0;
      if (sel0) begin
         wb_s_we      = wb_m0_we;
         wb_s_sel     = wb_m0_sel;
         wb_s_addr    = wb_m0_addr;
         wb_s_data_wr = wb_m0_data_wr;
      end else if (sel1) begin
         wb_s_we      = wb_m1_we;
         wb_s_sel     = wb_m1_sel;
         wb_s_addr    = wb_m1_addr;
         wb_s_data_wr = wb_m1_data_wr;
      end
   end

   // Abort err is raised in the IDLE cycle after the watchdog fires;
   // last_grant already names the aborted master there.
   assign wb_m0_ack     = sel0 & wb_s_ack;
   assign wb_m1_ack     = sel1 & wb_s_ack;
   assign wb_m0_err     = (sel0 & wb_s_err) | (o_timeout & ~last_grant);
   assign wb_m1_err     = (sel1 & wb_s_err) | (o_timeout & last_grant);
   assign wb_m0_data_rd = sel0 ? wb_s_data_rd : 32'h0;
   assign wb_m1_data_rd = sel1 ? wb_s_data_rd : 32'h0;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed and randomized checks of wb_arbiter2
// against a transaction-level arbitration and slave model.
module tb_wb_arbiter2;

   localparam int TO = 8;
   localparam logic [31:0] K = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]       m_cyc, m_stb, m_we;
   logic [1:0][3:0]  m_sel;
   logic [1:0][31:0] m_addr, m_wd;
   wire  [1:0]       m_ack, m_err;
   wire  [1:0][31:0] m_rd;

   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_addr, s_wd, s_rd;
   logic        s_ack, s_err;
   logic [1:0]  o_grant;
   logic        o_timeout;

   int checks = 0;
   int errors = 0;
   bit last_m = 1'b1;
   bit hang = 1'b0;
   logic [63:0] wlog[$];

   wb_arbiter2 #(.TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .wb_m0_cyc(m_cyc[0]), .wb_m0_stb(m_stb[0]), .wb_m0_we(m_we[0]),
      .wb_m0_sel(m_sel[0]), .wb_m0_addr(m_addr[0]),
      .wb_m0_data_wr(m_wd[0]), .wb_m0_data_rd(m_rd[0]),
      .wb_m0_ack(m_ack[0]), .wb_m0_err(m_err[0]),
      .wb_m1_cyc(m_cyc[1]), .wb_m1_stb(m_stb[1]), .wb_m1_we(m_we[1]),
      .wb_m1_sel(m_sel[1]), .wb_m1_addr(m_addr[1]),
      .wb_m1_data_wr(m_wd[1]), .wb_m1_data_rd(m_rd[1]),
      .wb_m1_ack(m_ack[1]), .wb_m1_err(m_err[1]),
      .wb_s_cyc(s_cyc), .wb_s_stb(s_stb), .wb_s_we(s_we),
      .wb_s_sel(s_sel), .wb_s_addr(s_addr), .wb_s_data_wr(s_wd),
      .wb_s_data_rd(s_rd), .wb_s_ack(s_ack), .wb_s_err(s_err),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   // Zero-latency slave: top nibble F -> err only, E -> ack and err.
   logic hit;
   assign hit   = s_cyc & s_stb & ~hang;
   assign s_ack = hit & (s_addr[31:28] != 4'hF);
   assign s_err = hit & (s_addr[31:28] == 4'hF || s_addr[31:28] == 4'hE);
   assign s_rd  = hit ? (s_addr ^ K) : 32'h0;

   always @(posedge clk)
      if (!rst && s_ack && s_we) wlog.push_back({s_addr, s_wd});

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int m, input logic [31:0] a, input logic w);
      m_cyc[m]  = 1'b1;
      m_stb[m]  = 1'b1;
      m_we[m]   = w;
      m_sel[m]  = 4'hF;
      m_addr[m] = a;
      m_wd[m]   = $urandom;
   endtask

   task automatic drop(input int m);
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      return $urandom & 32'h7FFF_FFFC;
   endfunction

   // One stb/ack transfer by the granted master m.
   task automatic xfer(input int m, input logic [31:0] a, input logic w);
      int n;
      bit ea, ee;
      logic [31:0] wd;
      n = 0;
      req(m, a, w);
      wd = m_wd[m];
      #1;
      while (!(m_ack[m] | m_err[m]) && n < 20) begin
         tick();
         n++;
      end
      ea = (a[31:28] != 4'hF);
      ee = (a[31:28] == 4'hF || a[31:28] == 4'hE);
      chk("resp_lat", 32'(n), 32'd0);
      chk("ack", 32'(m_ack[m]), 32'(ea));
      chk("err", 32'(m_err[m]), 32'(ee));
      chk("oth_ack", 32'(m_ack[1-m]), 32'd0);
      chk("oth_err", 32'(m_err[1-m]), 32'd0);
      chk("oth_rd", m_rd[1-m], 32'd0);
      chk("gnt_hold", 32'(o_grant), 32'(1 << m));
      chk("no_to", 32'(o_timeout), 32'd0);
      chk("sel", 32'(s_sel), 32'hF);
      if (ea && !w) chk("rdata", m_rd[m], a ^ K);
      tick();
      m_stb[m] = 1'b0;
      if (ea && w) begin
         chk("wr_cnt", 32'(wlog.size()), 32'd1);
         if (wlog.size() > 0) begin
            chk("wr_addr", wlog[$][63:32], a);
            chk("wr_data", wlog[$][31:0], wd);
         end
         wlog.delete();
      end
   endtask

   task automatic release_m(input int m);
      drop(m);
      #1;
      chk("rel_hold", 32'(o_grant), 32'(1 << m));
      tick();
      chk("idle_gap", 32'(o_grant), 32'd0);
      chk("idle_scyc", 32'(s_cyc), 32'd0);
   endtask

   task automatic tenure(input int m, input int nx);
      for (int i = 0; i < nx; i++)
         xfer(m, rnd_addr(), 1'($urandom_range(0, 1)));
      release_m(m);
      last_m = 1'(m);
   endtask

   // pat bit0 = m0 requests, bit1 = m1 requests, raised together.
   task automatic round(input int pat, input int nx);
      int w;
      if (pat[0]) req(0, rnd_addr(), 1'b0);
      if (pat[1]) req(1, rnd_addr(), 1'b0);
      #1;
      chk("arb_cycle", 32'(o_grant), 32'd0);
      chk("arb_scyc", 32'(s_cyc), 32'd0);
      if (pat == 1) w = 0;
      else if (pat == 2) w = 1;
`ifdef WBARB_FIXED_PRIORITY_EN
      else w = 0;
`else
      else w = last_m ? 0 : 1;
`endif
      tick();
      chk("grant", 32'(o_grant), 32'(1 << w));
      tenure(w, nx);
      if (pat == 3) begin
         tick();
         chk("grant2", 32'(o_grant), 32'(1 << (1 - w)));
         tenure(1 - w, nx);
      end
   endtask

   initial begin
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_sel = '0; m_addr = '0; m_wd = '0;
      req(0, 32'h10, 1'b0);
      #12;
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_to", 32'(o_timeout), 32'd0);
      chk("rst_scyc", 32'(s_cyc), 32'd0);
      chk("rst_sstb", 32'(s_stb), 32'd0);
      chk("rst_saddr", s_addr, 32'd0);
      chk("rst_m0ack", 32'(m_ack[0]), 32'd0);
      chk("rst_m0rd", m_rd[0], 32'd0);
      drop(0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // ties after reset: m0 first, then m0 again
      round(3, 1);
      round(3, 1);

      // single master read of 0x10
      req(0, 32'h10, 1'b0);
      #1;
      chk("s_arb", 32'(o_grant), 32'd0);
      tick();
      chk("s_grant", 32'(o_grant), 32'd1);
      xfer(0, 32'h10, 1'b0);
      release_m(0);
      last_m = 1'b0;

      // m1 burst of three writes while m0 waits
      req(1, 32'h0, 1'b1);
      tick();
      chk("b_grant", 32'(o_grant), 32'd2);
      req(0, rnd_addr(), 1'b0);
      xfer(1, 32'h0, 1'b1);
      xfer(1, 32'h4, 1'b1);
      xfer(1, 32'h8, 1'b1);
      release_m(1);
      tick();
      chk("b_grant0", 32'(o_grant), 32'd1);
      tenure(0, 1);

      // watchdog on a hung slave, m1 pending
      hang = 1'b1;
      req(0, 32'h100, 1'b0);
      tick();
      chk("w_grant", 32'(o_grant), 32'd1);
      req(1, 32'h200, 1'b0);
      for (int i = 1; i < TO; i++) begin
         tick();
         chk("w_noto", 32'(o_timeout), 32'd0);
         chk("w_noerr", 32'(m_err[0]), 32'd0);
         chk("w_scyc", 32'(s_cyc), 32'd1);
      end
      tick();
      chk("w_err", 32'(m_err[0]), 32'd1);
      chk("w_to", 32'(o_timeout), 32'd1);
      chk("w_scyc0", 32'(s_cyc), 32'd0);
      chk("w_idle", 32'(o_grant), 32'd0);
      chk("w_m1err", 32'(m_err[1]), 32'd0);
      hang = 1'b0;
      chk("w_late", 32'(m_ack[0]), 32'd0);
      tick();
      drop(0);
      chk("w_next", 32'(o_grant), 32'd2);
      chk("w_to_end", 32'(o_timeout), 32'd0);
      chk("w_err_end", 32'(m_err[0]), 32'd0);
      tenure(1, 1);

      // slave err passthrough, then ack+err together
      req(0, 32'hF000_0010, 1'b0);
      tick();
      chk("e_grant", 32'(o_grant), 32'd1);
      xfer(0, 32'hF000_0010, 1'b0);
      xfer(0, 32'hE000_0020, 1'b0);
      release_m(0);
      last_m = 1'b0;

      // randomized rounds
      repeat (30) round($urandom_range(1, 3), $urandom_range(1, 3));

      // async reset in the middle of an m1 tenure
      req(1, 32'h44, 1'b0);
      tick();
      chk("r_grant", 32'(o_grant), 32'd2);
      chk("r_ack", 32'(m_ack[1]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("r_scyc", 32'(s_cyc), 32'd0);
      chk("r_gnt0", 32'(o_grant), 32'd0);
      chk("r_ack0", 32'(m_ack[1]), 32'd0);
      chk("r_rd0", m_rd[1], 32'd0);
      drop(1);
      @(negedge clk);
      rst = 1'b0;
      last_m = 1'b1;
      tick();
      round(3, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter.
- Shares a single Wishbone peripheral (RAM/GPIO block) between master 0 (instruction fetch) and master 1 (load/store).
- Round-robin grant, held for the whole bus cycle (cyc high).
- Includes a bus watchdog that converts a hung slave into an err response.

Parameters:
- TIMEOUT, 64, max cycles a granted strobe may wait for ack/err before the arbiter aborts; must be >= 2.
- CNT_W, $clog2(TIMEOUT+1) (localparam), watchdog counter width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- wb_m0  interface  Wishbone.Peripheral  master 0 port (cyc, stb, we, sel[3:0], addr[31:0], data_wr[31:0] in; data_rd[31:0], ack, err out).
- wb_m1  interface  Wishbone.Peripheral  master 1 port, same signals.
- wb_s  interface  Wishbone.Controller  shared slave port (drives cyc, stb, we, sel, addr, data_wr; receives data_rd, ack, err).
- o_grant  output  2  one-hot registered grant {m1, m0}; 2'b00 when idle.
- o_timeout  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, GNT0, GNT1. Reset (async, i_rst=1) forces IDLE, last_grant=1 (so m0 wins first tie), watchdog=0, o_grant=0, o_timeout=0.
- While in reset and in IDLE:
  - wb_s.cyc/stb/we = 0; sel/addr/data_wr = 0.
  - Both masters see ack=0, err=0, data_rd=0.
- IDLE transitions (evaluated each clock edge):
  - Only m0.cyc -> GNT0.
  - Only m1.cyc -> GNT1.
  - Both -> the master not equal to last_grant.
  - Neither -> stay IDLE.
  - Grant is registered: slave sees the request one cycle after cyc rises (1-cycle arbitration latency). The stb of the arbitration cycle is not lost; the master holds stb until ack/err per Wishbone classic.
- GNTn: wb_s request signals driven combinationally from master n.
  - wb_s.data_rd, ack, err routed combinationally to master n only.
  - The other master sees ack=0, err=0, data_rd=0.
- Leaving GNTn: when master n drops cyc, next state is IDLE and last_grant=n. No back-to-back re-grant in the same cycle; one IDLE cycle minimum between tenures.
- Slave ack and err asserted together: both forwarded unchanged; the arbiter does not resolve them.
- Multiple transfers (several stb/ack pairs) within one cyc tenure stay with the same master; no preemption.
- Master drops cyc while a slave ack is arriving the same cycle: the ack is still forwarded combinationally, then state goes to IDLE.
- Watchdog:
  - Counter clears on any cycle with ack|err, on stb=0, or in IDLE.
  - Otherwise it increments while granted stb=1.
  - When counter == TIMEOUT-1 and no ack/err:
    - next cycle drives err=1 to master n (arbiter-generated) and o_timeout=1;
    - wb_s.cyc/stb forced 0 that cycle;
    - state -> IDLE, last_grant=n.
  - A late slave ack after abort is discarded (no master is granted).
- Reset mid-tenure: immediate return to IDLE; slave cyc drops asynchronously; any in-flight slave ack is ignored.

Optional Feature:
- Macro WBARB_FIXED_PRIORITY_EN.
- Defined: master 0 always wins simultaneous requests; last_grant is ignored for arbitration (still updated for debug).
- Undefined (default): round-robin as above.
- Either way, an active tenure is never preempted.

Test Plan:
- Single master: m0 reads 0x00000010 from a zero-latency slave -> o_grant=01 one cycle after cyc; m0 gets ack with slave data; m1 sees ack=0 throughout; o_grant returns to 00 after m0 drops cyc.
- Simultaneous requests after reset: m0 and m1 both raise cyc together -> m0 granted first; after m0 releases, one IDLE cycle, then m1 granted. Repeat the tie -> m0 granted again. With WBARB_FIXED_PRIORITY_EN, m0 wins every tie.
- Burst within tenure: m1 issues 3 writes to 0x0, 0x4, 0x8 under one cyc while m0 requests -> all 3 complete to m1; m0 is granted only after m1 drops cyc.
- Watchdog: TIMEOUT=8, slave never acks m0 -> exactly 8 cycles after grant, m0 receives err=1 for one cycle, o_timeout pulses, wb_s.cyc=0, state IDLE; a pending m1 request is granted next.
- Async reset mid-transfer: assert i_rst between clock edges during GNT1 -> wb_s.cyc=0 and o_grant=00 immediately; after release, a tie grants m0.
- Slave err passthrough: GPIO-range-invalid address returns err from slave -> err forwarded to the granted master only, the watchdog does not fire, and o_timeout stays 0.
